// File: rtl/regfile_param.sv
// Parametrised architectural register file with combinational read ports,
// optional hardwired zero register, write bypass and a sequenced clear sweep.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    RegWrite,
  input  logic [ADDR_W-1:0]       WriteRegister,
  input  logic [WIDTH-1:0]        WriteData,
  input  logic [NREAD*ADDR_W-1:0] ReadRegister,
  output logic [NREAD*WIDTH-1:0]  ReadData,
  input  logic                    Clear,
  output logic                    Busy,
  output logic                    WriteDropped
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_idx, w_idx_next;
  logic [WIDTH-1:0]  r_regs [DEPTH];
  logic              r_dropped;
  logic              w_wr_legal;
  logic              w_wr_en;

  assign w_wr_legal = (32'(WriteRegister) < 32'(DEPTH)) &&
                      !((ZERO_REG != 0) && (WriteRegister == '0));
  assign w_wr_en    = RegWrite && (r_state == S_IDLE) && w_wr_legal;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (Clear) begin
          w_state_next = S_CLEAR;
          w_idx_next   = '0;
        end
      end
      S_CLEAR: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = S_IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next   = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_dropped <= RegWrite && (r_state == S_CLEAR);
    end
  end

  // Sweep and host write never collide: host writes only commit in IDLE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int j = 0; j < DEPTH; j++) r_regs[j] <= '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((r_state == S_CLEAR) && (r_idx == ADDR_W'(j)))
          r_regs[j] <= '0;
        else if (w_wr_en && (WriteRegister == ADDR_W'(j)))
          r_regs[j] <= WriteData;
      end
    end
  end

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_read
    logic [ADDR_W-1:0] w_raddr;
    logic [WIDTH-1:0]  w_rdata;

    assign w_raddr = ReadRegister[gi*ADDR_W +: ADDR_W];

    // Addresses at or beyond DEPTH match no entry and fall through to zero.
    always_comb begin
      w_rdata = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (w_raddr == ADDR_W'(j)) w_rdata = r_regs[j];
      end
      if ((ZERO_REG != 0) && (w_raddr == '0)) w_rdata = '0;
      if ((BYPASS != 0) && w_wr_en && (w_raddr == WriteRegister)) w_rdata = WriteData;
    end

    assign ReadData[gi*WIDTH +: WIDTH] = w_rdata;
  end

  assign Busy         = (r_state == S_CLEAR);
  assign WriteDropped = r_dropped;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: expected values are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_regfile_param;

  logic        Clk;
  logic        Reset_n;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [9:0]  ReadRegister;
  logic [63:0] ReadData;
  logic        Clear;
  logic        Busy;
  logic        WriteDropped;

  regfile_param #(
    .WIDTH(32), .DEPTH(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .RegWrite(RegWrite),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister(ReadRegister), .ReadData(ReadData),
    .Clear(Clear), .Busy(Busy), .WriteDropped(WriteDropped)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;
  int   cyc;

  task automatic sb_push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
    ReadRegister = {a1, a0};
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    RegWrite      = 1'b1;
    WriteRegister = a;
    WriteData     = d;
    tick();
    RegWrite      = 1'b0;
  endtask

  task automatic check_pair(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [31:0] e0, input logic [31:0] e1);
    rd2(a0, a1);
    sb_push({tag, "_p0"}, e0);
    sb_push({tag, "_p1"}, e1);
    sb_check(ReadData[31:0]);
    sb_check(ReadData[63:32]);
    $display("read %s: r%0d=%0h r%0d=%0h", tag, a0, ReadData[31:0], a1, ReadData[63:32]);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    Reset_n       = 1'b0;
    RegWrite      = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    ReadRegister  = '0;
    Clear         = 1'b0;

    // Reset state
    tick();
    tick();
    sb_push("reset_busy", 32'd0);
    sb_check({31'd0, Busy});
    sb_push("reset_dropped", 32'd0);
    sb_check({31'd0, WriteDropped});
    Reset_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i += 2) check_pair("reset_read", 5'(i), 5'(i + 1), 32'd0, 32'd0);
    sb_push("post_reset_busy", 32'd0);
    sb_check({31'd0, Busy});

    // Basic write, then a disabled write must not take effect
    wr(5'd2, 32'd42);
    wr(5'd2, 32'd15);
    WriteRegister = 5'd2;
    WriteData     = 32'd99;
    tick();
    check_pair("basic_r2", 5'd2, 5'd2, 32'd15, 32'd15);
    check_pair("no_alias", 5'd3, 5'd4, 32'd0, 32'd0);

    // Zero register ignores writes, illegal write gives no drop pulse
    wr(5'd0, 32'hDEADBEEF);
    check_pair("zero_reg", 5'd0, 5'd0, 32'd0, 32'd0);
    sb_push("zero_no_drop", 32'd0);
    sb_check({31'd0, WriteDropped});

    // Bypass: port1 sees WriteData before the edge, port0 unaffected
    RegWrite      = 1'b1;
    WriteRegister = 5'd14;
    WriteData     = 32'd7;
    check_pair("bypass", 5'd4, 5'd14, 32'd0, 32'd7);
    tick();
    RegWrite = 1'b0;
    check_pair("bypass_commit", 5'd14, 5'd2, 32'd7, 32'd15);

    // No bypass for a write to the zero register
    RegWrite      = 1'b1;
    WriteRegister = 5'd0;
    WriteData     = 32'h1234;
    check_pair("zero_bypass", 5'd0, 5'd14, 32'd0, 32'd7);
    RegWrite = 1'b0;
    tick();

    // Fill and sweep
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    check_pair("fill", 5'd9, 5'd31, 32'd9, 32'd31);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    sb_push("sweep_busy_rise", 32'd1);
    sb_check({31'd0, Busy});
    cyc = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      if (cyc == 5) begin
        RegWrite      = 1'b1;
        WriteRegister = 5'd9;
        WriteData     = 32'h55;
        Clear         = 1'b1;
        check_pair("busy_no_bypass", 5'd9, 5'd20, 32'd9, 32'd20);
      end
      if (cyc == 10) check_pair("mid_sweep", 5'd5, 5'd20, 32'd0, 32'd20);
      tick();
      cyc++;
      if (cyc == 6) begin
        RegWrite = 1'b0;
        Clear    = 1'b0;
        sb_push("dropped_pulse", 32'd1);
        sb_check({31'd0, WriteDropped});
      end
      if (cyc == 7) begin
        sb_push("dropped_end", 32'd0);
        sb_check({31'd0, WriteDropped});
      end
    end
    sb_push("sweep_length", 32'd32);
    sb_check(32'(cyc));
    $display("sweep: busy cycles=%0d", cyc);
    for (int i = 0; i < 32; i += 2) check_pair("after_sweep", 5'(i), 5'(i + 1), 32'd0, 32'd0);

    // Async reset mid-sweep
    wr(5'd7, 32'h77);
    wr(5'd30, 32'h30);
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    tick();
    tick();
    #2;
    Reset_n = 1'b0;
    #1;
    sb_push("async_busy", 32'd0);
    sb_check({31'd0, Busy});
    check_pair("async_clear", 5'd7, 5'd30, 32'd0, 32'd0);
    tick();
    Reset_n = 1'b1;
    tick();
    sb_push("no_clear_memory", 32'd0);
    sb_check({31'd0, Busy});
    wr(5'd12, 32'hABCD);
    check_pair("post_reset_write", 5'd12, 5'd12, 32'hABCD, 32'hABCD);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
